// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: default bus widths, access
// sequencer state encoding and requester port identifiers.
// Imported by the arbiter, its round-robin picker and its bus interface.
package mem_port_arbiter_pkg;

  // 64-word memory, 16-bit instruction/data word (6-bit opcode + 4-bit reg + 6-bit addr)
  localparam int DEF_MEM_ADDR_SIZE = 6;
  localparam int DEF_WORD_SIZE     = 16;

  // Fixed four-phase access cycle
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    STROBE   = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Requester identities; also the encoding of last_grant
  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// Ports: fetch req/addr/ack/rdata, data req/we/addr/wdata/ack/rdata,
//        memory read/write/addr/wdata/rdata.
// master = requesters + memory side, slave = the arbiter itself.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int WORD_SIZE     = DEF_WORD_SIZE
) ();

  // instruction fetch port (read only)
  logic                     f_req;
  logic [MEM_ADDR_SIZE-1:0] f_addr;
  logic                     f_ack;
  logic [WORD_SIZE-1:0]     f_rdata;

  // load/store port
  logic                     d_req;
  logic                     d_we;
  logic [MEM_ADDR_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0]     d_wdata;
  logic                     d_ack;
  logic [WORD_SIZE-1:0]     d_rdata;

  // memory side
  logic                     mem_read;
  logic                     mem_write;
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0]     mem_wdata;
  logic [WORD_SIZE-1:0]     mem_rdata;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_rdata, d_ack, d_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_rdata, d_ack, d_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Purpose: two-way round-robin pick between fetch and data requests.
// Latency: combinational.
// Backpressure: none; caller samples the grant only when it can start an access.
// Ports: f_req, d_req, last_grant in; grant_valid, grant_id out.
module mem_rr_picker
  import mem_port_arbiter_pkg::*;
(
  input  logic  f_req,
  input  logic  d_req,
  input  port_t last_grant,
  output logic  grant_valid,
  output port_t grant_id
);

  always_comb begin
    grant_valid = f_req | d_req;
    grant_id    = PORT_FETCH;
    if (f_req && d_req) begin
      // contention: whoever was not served last goes first
      grant_id = other_port(last_grant);
    end else if (d_req) begin
      grant_id = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single-ported memory between fetch and data requesters.
// Latency: req sampled in IDLE at edge N -> ack during cycle N+3; 1 access / 4 cycles.
// Backpressure: requesters hold req until their ack; losers simply wait in IDLE.
// Ports: clk, reset_n (async active-low), bus (slave modport: both request
//        ports plus the memory strobes/address/data), busy (not IDLE).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int WORD_SIZE     = DEF_WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  // ---------------------------------------------------------------------
  // state and output registers (every output comes straight from a flop)
  // ---------------------------------------------------------------------
  state_t                   state_q,      state_d;
  port_t                    last_grant_q, last_grant_d;
  port_t                    lat_port_q,   lat_port_d;
  logic                     lat_we_q,     lat_we_d;
  logic                     mem_read_q,   mem_read_d;
  logic                     mem_write_q,  mem_write_d;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_q,   mem_addr_d;
  logic [WORD_SIZE-1:0]     mem_wdata_q,  mem_wdata_d;
  logic                     f_ack_q,      f_ack_d;
  logic                     d_ack_q,      d_ack_d;
  logic [WORD_SIZE-1:0]     f_rdata_q,    f_rdata_d;
  logic [WORD_SIZE-1:0]     d_rdata_q,    d_rdata_d;
  logic                     busy_q,       busy_d;

  logic  grant_valid;
  port_t grant_id;

  mem_rr_picker u_picker (
    .f_req       (bus.f_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_FETCH;
      lat_port_q   <= PORT_FETCH;
      lat_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_port_q   <= lat_port_d;
      lat_we_q     <= lat_we_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // next-state / next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_port_d   = lat_port_q;
    lat_we_d     = lat_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    // strobes and acks are single-cycle pulses
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = SETUP;
          last_grant_d = grant_id;
          lat_port_d   = grant_id;
          // The address/data output flops double as the access latch: they
          // are loaded once here and held through SETUP and STROBE, so the
          // requester is free to move its inputs after the grant.
          if (grant_id == PORT_DATA) begin
            lat_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            lat_we_d    = 1'b0;
            mem_addr_d  = bus.f_addr;
          end
        end
      end

      SETUP: begin
        // address/data have had a full cycle to settle; raise one strobe
        state_d     = STROBE;
        mem_read_d  = !lat_we_q;
        mem_write_d = lat_we_q;
      end

      STROBE: begin
        state_d = COMPLETE;
        // memory output is valid while mem_read is high; capture it here
        if (!lat_we_q) begin
          if (lat_port_q == PORT_FETCH) f_rdata_d = bus.mem_rdata;
          else                          d_rdata_d = bus.mem_rdata;
        end
        f_ack_d = (lat_port_q == PORT_FETCH);
        d_ack_d = (lat_port_q == PORT_DATA);
      end

      COMPLETE: begin
        // requests are not sampled here: a held req is seen again in IDLE
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.f_ack     = f_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic preload;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory (64 x 16) ----------------
  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];   // expected memory contents

  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // ---------------- reference model state ----------------
  logic [15:0] exp_f;
  logic [15:0] exp_d;
  port_t       last_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_f  = 16'h0000;
    exp_d  = 16'h0000;
    last_m = PORT_FETCH;
  endtask

  // one completed access in request order
  task automatic model_apply(input port_t p, input logic we, input logic [5:0] a,
                             input logic [15:0] wd);
    if (p == PORT_DATA && we)  ref_mem[a] = wd;
    else if (p == PORT_FETCH)  exp_f = ref_mem[a];
    else                       exp_d = ref_mem[a];
    last_m = p;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_acks"}, 32'({bus.f_ack, bus.d_ack}), 32'd0);
    chk({tag, "_f_rdata"}, 32'(bus.f_rdata), 32'd0);
    chk({tag, "_d_rdata"}, 32'(bus.d_rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    bus.f_req  = 1'b0;
    bus.d_req  = 1'b0;
    #1;
    chk_reset_vals("reset");
    tick();
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  // waits (bounded) for any ack; counts strobe cycles on the way
  task automatic wait_ack(input bit drop, output int lat, output int rd, output int wr,
                          output bit excl);
    lat = 0; rd = 0; wr = 0; excl = 1'b0;
    do begin
      tick();
      lat++;
      if (bus.mem_read)  rd++;
      if (bus.mem_write) wr++;
      if (bus.mem_read && bus.mem_write) excl = 1'b1;
      if (drop && lat == 1) begin
        // already granted: withdraw and scramble the request
        bus.f_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.f_addr  = bus.f_addr + 6'd1;
        bus.d_addr  = bus.d_addr + 6'd1;
        bus.d_wdata = ~bus.d_wdata;
      end
    end while (!(bus.f_ack || bus.d_ack) && lat < 12);
  endtask

  // issue fetch and/or data request from IDLE and check every resulting access
  task automatic run_txn(input bit f_on, input bit d_on, input logic [5:0] fa,
                         input logic we, input logic [5:0] da, input logic [15:0] wd,
                         input bit drop);
    port_t order [2];
    int    n, lat, rd, wr;
    bit    excl, is_w;
    bus.f_req = f_on; bus.f_addr = fa;
    bus.d_req = d_on; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
    if (f_on && d_on) begin
      order[0] = (last_m == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
      order[1] = (order[0] == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
      n = 2;
    end else begin
      order[0] = f_on ? PORT_FETCH : PORT_DATA;
      order[1] = order[0];
      n = 1;
    end
    for (int k = 0; k < n; k++) begin
      wait_ack(drop && k == 0, lat, rd, wr, excl);
      is_w = (order[k] == PORT_DATA) && we;
      model_apply(order[k], we, (order[k] == PORT_FETCH) ? fa : da, wd);
      chk("ack_latency", 32'(lat), (k == 0) ? 32'd3 : 32'd4);
      chk("f_ack", 32'(bus.f_ack), 32'(order[k] == PORT_FETCH));
      chk("d_ack", 32'(bus.d_ack), 32'(order[k] == PORT_DATA));
      chk("f_rdata", 32'(bus.f_rdata), 32'(exp_f));
      chk("d_rdata", 32'(bus.d_rdata), 32'(exp_d));
      chk("read_strobes", 32'(rd), is_w ? 32'd0 : 32'd1);
      chk("write_strobes", 32'(wr), is_w ? 32'd1 : 32'd0);
      chk("strobe_overlap", 32'(excl), 32'd0);
      if (order[k] == PORT_FETCH) bus.f_req = 1'b0;
      else                        bus.d_req = 1'b0;
    end
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_acks", 32'({bus.f_ack, bus.d_ack}), 32'd0);
  endtask

  initial begin
    int lat, rd, wr;
    bit excl;
    port_t p;
    int ack_at [2];
    int na, idle_between, mode;

    reset_n = 1'b0;
    preload = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
    ref_mem[0]  = 16'h0450;
    ref_mem[1]  = 16'h0461;
    ref_mem[2]  = 16'h2400;
    ref_mem[3]  = 16'h3cc3;
    ref_mem[20] = 16'h0014;
    preload = 1'b1;
    tick();
    preload = 1'b0;

    // reset values, then a plain fetch of address 0
    do_reset();
    run_txn(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 16'h0, 1'b0);
    chk("fetch0_value", 32'(bus.f_rdata), 32'h0450);

    // both requesters held straight out of reset: DATA first, then alternate
    reset_n   = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 6'd1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd20;
    tick();
    tick();
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, lat, rd, wr, excl);
      p = (last_m == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
      model_apply(p, 1'b0, (p == PORT_FETCH) ? 6'd1 : 6'd20, 16'h0);
      chk("rr_latency", 32'(lat), (k == 0) ? 32'd3 : 32'd4);
      chk("rr_f_ack", 32'(bus.f_ack), 32'(p == PORT_FETCH));
      chk("rr_d_ack", 32'(bus.d_ack), 32'(p == PORT_DATA));
      chk("rr_f_rdata", 32'(bus.f_rdata), 32'(exp_f));
      chk("rr_d_rdata", 32'(bus.d_rdata), 32'(exp_d));
      if (k == 0) chk("rr_first_data", 32'(bus.d_rdata), 32'h0014);
      if (k == 3) begin bus.f_req = 1'b0; bus.d_req = 1'b0; end
    end
    tick();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // fetch addr 2, request dropped and address moved right after grant
    run_txn(1'b1, 1'b0, 6'd2, 1'b0, 6'd0, 16'h0, 1'b1);
    chk("drop_value", 32'(bus.f_rdata), 32'h2400);

    // write then read back through the data port
    run_txn(1'b0, 1'b1, 6'd0, 1'b1, 6'd5, 16'h1234, 1'b0);
    run_txn(1'b0, 1'b1, 6'd0, 1'b0, 6'd5, 16'h0, 1'b0);
    chk("readback_value", 32'(bus.d_rdata), 32'h1234);

    // reset during STROBE of a data read
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd20;
    tick();
    tick();
    chk("abort_in_strobe", 32'(bus.mem_read), 32'd1);
    #2;
    reset_n   = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk_reset_vals("abort");
    tick();
    chk("abort_no_ack", 32'(bus.d_ack), 32'd0);
    tick();
    chk("abort_no_ack2", 32'(bus.d_ack), 32'd0);
    reset_n = 1'b1;
    model_reset();

    // back-to-back writes with d_req held
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd6; bus.d_wdata = 16'hbeef;
    ack_at[0] = 0; ack_at[1] = 0; na = 0; idle_between = 0;
    for (int k = 1; k <= 12 && na < 2; k++) begin
      tick();
      if (na == 1 && !busy) idle_between++;
      if (bus.d_ack) begin
        ack_at[na] = k;
        na++;
        if (na == 2) bus.d_req = 1'b0;
      end
    end
    chk("b2b_ack_count", 32'(na), 32'd2);
    chk("b2b_first_ack", 32'(ack_at[0]), 32'd3);
    chk("b2b_second_ack", 32'(ack_at[1]), 32'd7);
    chk("b2b_idle_cycles", 32'(idle_between), 32'd1);
    chk("b2b_rdata_kept", 32'({bus.f_rdata, bus.d_rdata}), 32'd0);
    ref_mem[6] = 16'hbeef;
    last_m     = PORT_DATA;
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    run_txn(1'b1, 1'b0, 6'd6, 1'b0, 6'd0, 16'h0, 1'b0);
    chk("b2b_value", 32'(bus.f_rdata), 32'hbeef);

    // randomized mix of single and contended accesses
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      run_txn(mode != 1, mode != 0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 63)), 16'($urandom),
              (mode != 2) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
